// File: rtl/axi_read_arbiter_if.sv
// AXI3/4 bundle (32-bit address and data, 4-bit IDs) shared by the upstream ports and the SoC master.
// master drives AR/AW/W and the R/B ready signals; slave is the mirror image.
interface axi_read_arbiter_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [3:0]  arcache;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [3:0]  awcache;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arcache, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awcache, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arcache, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awcache, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_read_arbiter.sv
// Merges instruction and data AXI reads onto one master, one read outstanding; data writes pass straight through.
// Define ARB_RR_EN for round-robin between simultaneous reads; otherwise data always wins.
module axi_read_arbiter #(
    parameter logic [3:0] INST_ARID = 4'd0,
    parameter logic [3:0] DATA_ARID = 4'd1
) (
    input  logic               clk,
    input  logic               reset,
    axi_read_arbiter_if.slave  inst,
    axi_read_arbiter_if.slave  data,
    axi_read_arbiter_if.master m
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_e;
    typedef enum logic {PORT_DATA, PORT_INST} port_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [3:0]  cache;
    } ar_req_t;

    state_e  state_q;
    port_e   grant_q;
    ar_req_t ar_q;
    ar_req_t ar_d;
    logic    m_arvalid_q;
    logic    pick_inst;
    logic    idle_ok;
    logic    in_resp;
    logic    grant_inst;
    logic    unused_inputs;

`ifdef ARB_RR_EN
    // Holds the last contested winner; resetting it to inst makes the first contest go to data.
    port_e rr_last_q;

    assign pick_inst = inst.arvalid & (~data.arvalid | (rr_last_q == PORT_DATA));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_last_q <= PORT_INST;
        end else if (state_q == S_IDLE && inst.arvalid && data.arvalid) begin
            rr_last_q <= pick_inst ? PORT_INST : PORT_DATA;
        end
    end
`else
    assign pick_inst = inst.arvalid & ~data.arvalid;
`endif

    // NOTE: arready is combinational, so it must be gated by reset explicitly to stay low while reset is held.
    assign idle_ok      = reset & (state_q == S_IDLE);
    assign inst.arready = idle_ok & pick_inst;
    assign data.arready = idle_ok & data.arvalid & ~pick_inst;

    assign ar_d = pick_inst
        ? {inst.araddr, inst.arlen, inst.arsize, inst.arburst, inst.arcache}
        : {data.araddr, data.arlen, data.arsize, data.arburst, data.arcache};

    // NOTE: non-blocking assignments keep every register sampling the pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            grant_q     <= PORT_DATA;
            ar_q        <= '0;
            m_arvalid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (inst.arvalid || data.arvalid) begin
                        grant_q     <= pick_inst ? PORT_INST : PORT_DATA;
                        ar_q        <= ar_d;
                        m_arvalid_q <= 1'b1;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (m.arready) begin
                        m_arvalid_q <= 1'b0;
                        state_q     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (m.rvalid && m.rready && m.rlast) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign grant_inst = (grant_q == PORT_INST);
    assign in_resp    = (state_q == S_RESP);

    assign m.arvalid = m_arvalid_q;
    assign m.arid    = grant_inst ? INST_ARID : DATA_ARID;
    assign m.araddr  = ar_q.addr;
    assign m.arlen   = ar_q.len;
    assign m.arsize  = ar_q.size;
    assign m.arburst = ar_q.burst;
    assign m.arcache = ar_q.cache;

    // Payload fans out to both ports; only the granted port ever sees rvalid.
    assign inst.rid    = m.rid;
    assign inst.rdata  = m.rdata;
    assign inst.rresp  = m.rresp;
    assign inst.rlast  = m.rlast;
    assign inst.rvalid = in_resp & grant_inst & m.rvalid;
    assign data.rid    = m.rid;
    assign data.rdata  = m.rdata;
    assign data.rresp  = m.rresp;
    assign data.rlast  = m.rlast;
    assign data.rvalid = in_resp & ~grant_inst & m.rvalid;
    assign m.rready    = in_resp & (grant_inst ? inst.rready : data.rready);

    assign m.awid      = data.awid;
    assign m.awaddr    = data.awaddr;
    assign m.awlen     = data.awlen;
    assign m.awsize    = data.awsize;
    assign m.awburst   = data.awburst;
    assign m.awcache   = data.awcache;
    assign m.awvalid   = data.awvalid;
    assign data.awready = m.awready;
    assign m.wid       = data.wid;
    assign m.wdata     = data.wdata;
    assign m.wstrb     = data.wstrb;
    assign m.wlast     = data.wlast;
    assign m.wvalid    = data.wvalid;
    assign data.wready = m.wready;
    assign data.bid    = m.bid;
    assign data.bresp  = m.bresp;
    assign data.bvalid = m.bvalid;
    assign m.bready    = data.bready;

    // The instruction side never writes.
    assign inst.awready = 1'b0;
    assign inst.wready  = 1'b0;
    assign inst.bvalid  = 1'b0;
    assign inst.bid     = 4'd0;
    assign inst.bresp   = 2'd0;

    assign unused_inputs = ^{inst.arid, data.arid,
                             inst.awid, inst.awaddr, inst.awlen, inst.awsize, inst.awburst,
                             inst.awcache, inst.awvalid, inst.wid, inst.wdata, inst.wstrb,
                             inst.wlast, inst.wvalid, inst.bready};

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: vector table of single-port reads plus hand sequences
// for arbitration order, AR stall, concurrent write and mid-burst reset.
module tb_axi_read_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    axi_read_arbiter_if inst_if ();
    axi_read_arbiter_if data_if ();
    axi_read_arbiter_if m_if ();

    axi_read_arbiter #(
        .INST_ARID(4'd0),
        .DATA_ARID(4'd1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .inst (inst_if),
        .data (data_if),
        .m    (m_if)
    );

`ifdef ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          to_inst;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [31:0] rdata;
        logic [3:0]  exp_arid;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive AR requests at a negedge, check arready, then advance to the next negedge.
    task automatic arb_req(input bit iv, input bit dv, input logic [31:0] ia, input logic [31:0] da,
                           input logic [7:0] len, input bit exp_ir, input bit exp_dr, input string tag);
        inst_if.arvalid = iv;  inst_if.araddr = ia;  inst_if.arlen = len;
        inst_if.arsize  = 3'd2; inst_if.arburst = 2'b01; inst_if.arcache = 4'h3;
        data_if.arvalid = dv;  data_if.araddr = da;  data_if.arlen = len;
        data_if.arsize  = 3'd2; data_if.arburst = 2'b01; data_if.arcache = 4'h3;
        #1;
        check({tag, "_inst_arready"}, inst_if.arready, exp_ir);
        check({tag, "_data_arready"}, data_if.arready, exp_dr);
        @(negedge clk);
    endtask

    task automatic arb_issue(input logic [3:0] exp_arid, input logic [31:0] addr,
                             input logic [7:0] len, input string tag);
        #1;
        check({tag, "_m_arvalid"}, m_if.arvalid, 1'b1);
        check({tag, "_m_araddr"}, m_if.araddr, addr);
        check({tag, "_m_arid"}, m_if.arid, exp_arid);
        check({tag, "_m_arlen"}, m_if.arlen, len);
        check({tag, "_m_arsize"}, m_if.arsize, 3'd2);
        check({tag, "_busy_inst_arready"}, inst_if.arready, 1'b0);
        check({tag, "_busy_data_arready"}, data_if.arready, 1'b0);
        m_if.arready = 1'b1;
        @(negedge clk);
        m_if.arready = 1'b0;
    endtask

    task automatic serve(input bit to_inst, input int n, input logic [31:0] base,
                         input bit end_last, input string tag);
        for (int i = 0; i < n; i++) begin
            m_if.rvalid = 1'b1;
            m_if.rdata  = base + i;
            m_if.rlast  = end_last && (i == n - 1);
            m_if.rid    = to_inst ? 4'd0 : 4'd1;
            #1;
            check({tag, "_grant_rvalid"}, to_inst ? inst_if.rvalid : data_if.rvalid, 1'b1);
            check({tag, "_other_rvalid"}, to_inst ? data_if.rvalid : inst_if.rvalid, 1'b0);
            check({tag, "_rdata"}, to_inst ? inst_if.rdata : data_if.rdata, base + i);
            check({tag, "_rlast"}, to_inst ? inst_if.rlast : data_if.rlast, end_last && (i == n - 1));
            check({tag, "_m_rready"}, m_if.rready, 1'b1);
            @(negedge clk);
        end
        m_if.rvalid = 1'b0;
        m_if.rlast  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit first_inst;

        vecs[0] = '{1'b1, 32'h1FC0_0000, 8'd0, 32'hDEAD_BEEF, 4'd0};
        vecs[1] = '{1'b0, 32'h8000_1000, 8'd1, 32'hA5A5_0000, 4'd1};
        vecs[2] = '{1'b1, 32'h1FC0_0040, 8'd3, 32'h0000_1000, 4'd0};
        vecs[3] = '{1'b0, 32'h0000_0FFC, 8'd0, 32'hFFFF_FFFF, 4'd1};

        inst_if.arvalid = 1'b0; inst_if.araddr = '0; inst_if.arlen = '0; inst_if.arid = '0;
        inst_if.arsize = '0; inst_if.arburst = '0; inst_if.arcache = '0; inst_if.rready = 1'b1;
        inst_if.awvalid = 1'b0; inst_if.awid = '0; inst_if.awaddr = '0; inst_if.awlen = '0;
        inst_if.awsize = '0; inst_if.awburst = '0; inst_if.awcache = '0;
        inst_if.wvalid = 1'b0; inst_if.wid = '0; inst_if.wdata = '0; inst_if.wstrb = '0;
        inst_if.wlast = 1'b0; inst_if.bready = 1'b0;
        data_if.arvalid = 1'b0; data_if.araddr = '0; data_if.arlen = '0; data_if.arid = '0;
        data_if.arsize = '0; data_if.arburst = '0; data_if.arcache = '0; data_if.rready = 1'b1;
        data_if.awvalid = 1'b0; data_if.awid = '0; data_if.awaddr = '0; data_if.awlen = '0;
        data_if.awsize = '0; data_if.awburst = '0; data_if.awcache = '0;
        data_if.wvalid = 1'b0; data_if.wid = '0; data_if.wdata = '0; data_if.wstrb = '0;
        data_if.wlast = 1'b0; data_if.bready = 1'b0;
        m_if.arready = 1'b0; m_if.rvalid = 1'b0; m_if.rdata = '0; m_if.rresp = '0;
        m_if.rlast = 1'b0; m_if.rid = '0; m_if.awready = 1'b0; m_if.wready = 1'b0;
        m_if.bvalid = 1'b0; m_if.bid = '0; m_if.bresp = '0;

        // Reset state, with a request already pending on the inst side.
        @(negedge clk);
        inst_if.arvalid = 1'b1;
        #1;
        check("rst_inst_arready", inst_if.arready, 1'b0);
        check("rst_data_arready", data_if.arready, 1'b0);
        check("rst_m_arvalid", m_if.arvalid, 1'b0);
        check("rst_m_araddr", m_if.araddr, 32'h0);
        check("rst_inst_rvalid", inst_if.rvalid, 1'b0);
        check("rst_data_rvalid", data_if.rvalid, 1'b0);
        @(negedge clk);
        inst_if.arvalid = 1'b0;
        reset = 1'b1;
        @(negedge clk);

        // Single-requester reads from the vector table.
        for (int v = 0; v < 4; v++) begin
            arb_req(vecs[v].to_inst, !vecs[v].to_inst, vecs[v].addr, vecs[v].addr, vecs[v].len,
                    vecs[v].to_inst, !vecs[v].to_inst, $sformatf("vec%0d", v));
            inst_if.arvalid = 1'b0;
            data_if.arvalid = 1'b0;
            arb_issue(vecs[v].exp_arid, vecs[v].addr, vecs[v].len, $sformatf("vec%0d", v));
            serve(vecs[v].to_inst, int'(vecs[v].len) + 1, vecs[v].rdata, 1'b1, $sformatf("vec%0d", v));
        end

        // Two rounds of simultaneous requests; the loser keeps asking while the winner is served.
        for (int r = 0; r < 2; r++) begin
            first_inst = (r == 1) && RR_EN;
            arb_req(1'b1, 1'b1, 32'h1FC0_0100, 32'h8000_2000, 8'd0, first_inst, !first_inst,
                    $sformatf("contest%0d_a", r));
            if (first_inst) inst_if.arvalid = 1'b0;
            else            data_if.arvalid = 1'b0;
            arb_issue(first_inst ? 4'd0 : 4'd1, first_inst ? 32'h1FC0_0100 : 32'h8000_2000, 8'd0,
                      $sformatf("contest%0d_a", r));
            serve(first_inst, 1, 32'h0000_00A0, 1'b1, $sformatf("contest%0d_a", r));
            arb_req(!first_inst, first_inst, 32'h1FC0_0100, 32'h8000_2000, 8'd0, !first_inst, first_inst,
                    $sformatf("contest%0d_b", r));
            inst_if.arvalid = 1'b0;
            data_if.arvalid = 1'b0;
            arb_issue(first_inst ? 4'd1 : 4'd0, first_inst ? 32'h8000_2000 : 32'h1FC0_0100, 8'd0,
                      $sformatf("contest%0d_b", r));
            serve(!first_inst, 1, 32'h0000_00B0, 1'b1, $sformatf("contest%0d_b", r));
        end

        // m_arready held low for 5 cycles while upstream arvalids wiggle.
        arb_req(1'b0, 1'b1, 32'h0, 32'h8000_3000, 8'd0, 1'b0, 1'b1, "stall");
        data_if.arvalid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            inst_if.arvalid = 1'b1;
            data_if.arvalid = k[0];
            #1;
            check($sformatf("stall%0d_m_arvalid", k), m_if.arvalid, 1'b1);
            check($sformatf("stall%0d_m_araddr", k), m_if.araddr, 32'h8000_3000);
            check($sformatf("stall%0d_inst_arready", k), inst_if.arready, 1'b0);
            check($sformatf("stall%0d_data_arready", k), data_if.arready, 1'b0);
            @(negedge clk);
        end
        inst_if.arvalid = 1'b0;
        data_if.arvalid = 1'b0;
        arb_issue(4'd1, 32'h8000_3000, 8'd0, "stall");
        serve(1'b0, 1, 32'h0000_0C00, 1'b1, "stall");

        // Data write while an inst burst of 4 beats is in flight.
        arb_req(1'b1, 1'b0, 32'h0040_0000, 32'h0, 8'd3, 1'b1, 1'b0, "wr");
        inst_if.arvalid = 1'b0;
        arb_issue(4'd0, 32'h0040_0000, 8'd3, "wr");
        data_if.awvalid = 1'b1; data_if.awaddr = 32'h0000_1000; data_if.awid = 4'd5;
        data_if.wvalid = 1'b1; data_if.wdata = 32'h1234_5678; data_if.wstrb = 4'hF; data_if.wlast = 1'b1;
        inst_if.awvalid = 1'b1; inst_if.wvalid = 1'b1;
        m_if.awready = 1'b1; m_if.wready = 1'b1;
        m_if.rvalid = 1'b1; m_if.rdata = 32'h5555_0000; inst_if.rready = 1'b0;
        #1;
        check("wr_m_awvalid", m_if.awvalid, 1'b1);
        check("wr_m_awaddr", m_if.awaddr, 32'h0000_1000);
        check("wr_m_awid", m_if.awid, 4'd5);
        check("wr_m_wdata", m_if.wdata, 32'h1234_5678);
        check("wr_m_wstrb", m_if.wstrb, 4'hF);
        check("wr_data_awready", data_if.awready, 1'b1);
        check("wr_data_wready", data_if.wready, 1'b1);
        check("wr_inst_awready", inst_if.awready, 1'b0);
        check("wr_inst_wready", inst_if.wready, 1'b0);
        check("wr_backpressure_m_rready", m_if.rready, 1'b0);
        @(negedge clk);
        data_if.awvalid = 1'b0; data_if.wvalid = 1'b0;
        inst_if.awvalid = 1'b0; inst_if.wvalid = 1'b0; inst_if.bready = 1'b1;
        m_if.awready = 1'b0; m_if.wready = 1'b0; m_if.rvalid = 1'b0; inst_if.rready = 1'b1;
        m_if.bvalid = 1'b1; m_if.bid = 4'd5; m_if.bresp = 2'd0; data_if.bready = 1'b1;
        #1;
        check("wr_data_bvalid", data_if.bvalid, 1'b1);
        check("wr_data_bid", data_if.bid, 4'd5);
        check("wr_m_bready", m_if.bready, 1'b1);
        check("wr_inst_bvalid", inst_if.bvalid, 1'b0);
        @(negedge clk);
        m_if.bvalid = 1'b0; data_if.bready = 1'b0; inst_if.bready = 1'b0;
        serve(1'b1, 4, 32'h5555_0000, 1'b1, "wr_burst");

        // Reset in the middle of a 4-beat burst, after beat 2.
        arb_req(1'b1, 1'b0, 32'h1FC0_0200, 32'h0, 8'd3, 1'b1, 1'b0, "mid");
        inst_if.arvalid = 1'b0;
        arb_issue(4'd0, 32'h1FC0_0200, 8'd3, "mid");
        serve(1'b1, 2, 32'h7777_0000, 1'b0, "mid");
        m_if.rvalid = 1'b1; m_if.rdata = 32'h7777_0002;
        inst_if.arvalid = 1'b1;
        reset = 1'b0;
        #1;
        check("mid_rst_inst_rvalid", inst_if.rvalid, 1'b0);
        check("mid_rst_data_rvalid", data_if.rvalid, 1'b0);
        check("mid_rst_m_arvalid", m_if.arvalid, 1'b0);
        check("mid_rst_m_rready", m_if.rready, 1'b0);
        check("mid_rst_inst_arready", inst_if.arready, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        inst_if.arvalid = 1'b0;
        #1;
        check("mid_post_inst_rvalid", inst_if.rvalid, 1'b0);
        check("mid_post_m_rready", m_if.rready, 1'b0);
        @(negedge clk);
        m_if.rvalid = 1'b0;
        arb_req(1'b0, 1'b1, 32'h0, 32'h8000_4000, 8'd0, 1'b0, 1'b1, "after");
        data_if.arvalid = 1'b0;
        arb_issue(4'd1, 32'h8000_4000, 8'd0, "after");
        serve(1'b0, 1, 32'h0000_0D00, 1'b1, "after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
